// File: rtl/alu_lfsr_sequencer_pkg.sv
// Shared ALU opcode mnemonics and sequencer state encoding for the LFSR keystream controller.
// The optional parity-bit stage is enabled by defining LFSR_SEQ_PARITY_EN.
package definitions;

    typedef enum logic [3:0] {
        kADD        = 4'h0,
        kSUB        = 4'h1,
        kAND        = 4'h2,
        kOR         = 4'h3,
        kXOR        = 4'h4,
        kNOT        = 4'h5,
        kSHL        = 4'h6,
        kSHR        = 4'h7,
        kLFSR       = 4'h8,
        kPARITY_BIT = 4'h9
    } op_mne;

    // PAR is only visited when the parity stage is built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        PAR  = 2'd2,
        EMIT = 2'd3
    } seq_state_t;

    localparam int LFSR_W = 7;

endpackage

// File: rtl/alu_lfsr_sequencer_if.sv
// ALU operand/result lines plus the keystream valid/ready stream between the sequencer and its neighbours.
// The master side is the sequencer; the slave side is the ALU and keystream consumer.
interface alu_lfsr_sequencer_if;

    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_out;
    logic [7:0] ks_data;
    logic       ks_valid;
    logic       ks_ready;

    modport master (
        output alu_op,
        output alu_a,
        output alu_b,
        input  alu_out,
        output ks_data,
        output ks_valid,
        input  ks_ready
    );

    modport slave (
        input  alu_op,
        input  alu_a,
        input  alu_b,
        output alu_out,
        input  ks_data,
        input  ks_valid,
        output ks_ready
    );

endinterface

// File: rtl/alu_lfsr_sequencer.sv
// Drives the external ALU through repeated kLFSR steps and streams one keystream byte per step.
// Defining LFSR_SEQ_PARITY_EN adds a PAR state that folds the state parity into bit 7 of each byte.
module alu_lfsr_sequencer
    import definitions::*;
#(
    parameter int LEN_W = 6
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       start,
    input  logic [LFSR_W-1:0]          tap,
    input  logic [LFSR_W-1:0]          seed,
    input  logic [LEN_W-1:0]           len,
    alu_lfsr_sequencer_if.master       bus,
    output logic                       busy,
    output logic                       done
);

    seq_state_t          cur_state;
    logic [LFSR_W-1:0]   tap_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [LEN_W-1:0]    count_q;
    logic [7:0]          ks_data_q;
    logic                ks_valid_q;
    logic                done_q;

    // The ALU result is only trusted in STEP/PAR; EMIT holds the byte until the consumer takes it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_state  <= IDLE;
            tap_q      <= '0;
            lfsr_q     <= '0;
            count_q    <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (start) begin
                        tap_q   <= tap;
                        lfsr_q  <= seed;
                        count_q <= len;
                        if (len != '0) begin
                            cur_state <= STEP;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    lfsr_q    <= bus.alu_out[LFSR_W-1:0];
                    ks_data_q <= {1'b0, bus.alu_out[LFSR_W-1:0]};
`ifdef LFSR_SEQ_PARITY_EN
                    cur_state <= PAR;
`else
                    ks_valid_q <= 1'b1;
                    cur_state  <= EMIT;
`endif
                end
`ifdef LFSR_SEQ_PARITY_EN
                PAR: begin
                    ks_data_q  <= bus.alu_out;
                    ks_valid_q <= 1'b1;
                    cur_state  <= EMIT;
                end
`endif
                EMIT: begin
                    if (bus.ks_ready) begin
                        ks_valid_q <= 1'b0;
                        count_q    <= count_q - LEN_W'(1);
                        if (count_q == LEN_W'(1)) begin
                            cur_state <= IDLE;
                            done_q    <= 1'b1;
                        end else begin
                            cur_state <= STEP;
                        end
                    end
                end
                default: begin
                    cur_state <= IDLE;
                end
            endcase
        end
    end

    // Operand lines are parked at zero whenever the ALU result is not being consumed.
    always_comb begin
        bus.alu_op = 4'h0;
        bus.alu_a  = 8'h00;
        bus.alu_b  = 8'h00;
        case (cur_state)
            STEP: begin
                bus.alu_op = kLFSR;
                bus.alu_a  = {1'b0, tap_q};
                bus.alu_b  = {1'b0, lfsr_q};
            end
            PAR: begin
                bus.alu_op = kPARITY_BIT;
                bus.alu_b  = {1'b0, lfsr_q};
            end
            default: begin
            end
        endcase
    end

    assign bus.ks_data  = ks_data_q;
    assign bus.ks_valid = ks_valid_q;
    assign busy         = (cur_state != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_alu_lfsr_sequencer.sv
// Directed bench for alu_lfsr_sequencer with a behavioural ALU beside it.
// Expected bytes follow the build: LFSR_SEQ_PARITY_EN selects the parity-extended table.
module tb_alu_lfsr_sequencer;
    import definitions::*;

    localparam int LEN_W = 6;

`ifdef LFSR_SEQ_PARITY_EN
    localparam int BYTE_CYCLES = 3;
    logic [7:0] exp_bytes [0:6] = '{8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h41, 8'h03};
`else
    localparam int BYTE_CYCLES = 2;
    logic [7:0] exp_bytes [0:6] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03};
`endif

    logic             Clk = 1'b0;
    logic             Reset;
    logic             start;
    logic [6:0]       tap;
    logic [6:0]       seed;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    alu_lfsr_sequencer_if bus ();

    alu_lfsr_sequencer #(.LEN_W(LEN_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start),
        .tap   (tap),
        .seed  (seed),
        .len   (len),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 Clk = ~Clk;

    // Reference ALU: shift left, feed back the tap-masked parity; parity op puts XOR of B[6:0] in bit 7.
    always_comb begin
        case (bus.alu_op)
            kLFSR:       bus.alu_out = {1'b0, bus.alu_b[5:0], ^(bus.alu_a[6:0] & bus.alu_b[6:0])};
            kPARITY_BIT: bus.alu_out = {^bus.alu_b[6:0], bus.alu_b[6:0]};
            default:     bus.alu_out = 8'h00;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [6:0] tp, input logic [6:0] sd,
                                 input logic [LEN_W-1:0] ln, input logic rdy);
        start        = st;
        tap          = tp;
        seed         = sd;
        len          = ln;
        bus.ks_ready = rdy;
    endtask

    // Starts a run and receives nRecv bytes; optionally stalls one byte or fires a stray start.
    task automatic runStream(input logic [6:0] tp, input logic [6:0] sd, input logic [LEN_W-1:0] ln,
                             input int nRecv, input int stallIdx, input int intrudeIdx);
        int cycles;
        applyStimulus(1'b1, tp, sd, ln, 1'b1);
        for (int i = 0; i < nRecv; i++) begin
            cycles = 0;
            do begin
                @(negedge Clk);
                cycles++;
                start = 1'b0;
                if (i == 0 && cycles == 1) begin
                    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
                    checkOutput("step_alu_op", {28'b0, bus.alu_op}, {28'b0, kLFSR});
                    checkOutput("step_alu_a", {24'b0, bus.alu_a}, {25'b0, tp});
                    checkOutput("step_alu_b", {24'b0, bus.alu_b}, {25'b0, sd});
                end
            end while (!bus.ks_valid && cycles < 20);
            checkOutput($sformatf("byte%0d_latency", i), cycles, BYTE_CYCLES);
            checkOutput($sformatf("byte%0d_data", i), {24'b0, bus.ks_data}, {24'b0, exp_bytes[i]});
            checkOutput("done_low_midrun", {31'b0, done}, 32'd0);
            if (i == stallIdx) begin
                bus.ks_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge Clk);
                    checkOutput("stall_valid", {31'b0, bus.ks_valid}, 32'd1);
                    checkOutput("stall_data", {24'b0, bus.ks_data}, {24'b0, exp_bytes[i]});
                    checkOutput("stall_alu_op", {28'b0, bus.alu_op}, 32'd0);
                end
                bus.ks_ready = 1'b1;
            end
            if (i == intrudeIdx) begin
                start = 1'b1;
                seed  = 7'h55;
                tap   = 7'h7F;
            end
        end
    endtask

    task automatic checkEndOfRun();
        @(negedge Clk);
        checkOutput("done_pulse", {31'b0, done}, 32'd1);
        checkOutput("busy_drop", {31'b0, busy}, 32'd0);
        checkOutput("valid_drop", {31'b0, bus.ks_valid}, 32'd0);
        @(negedge Clk);
        checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        applyStimulus(1'b0, 7'h00, 7'h00, '0, 1'b0);
        repeat (3) @(negedge Clk);
        checkOutput("rst_valid", {31'b0, bus.ks_valid}, 32'd0);
        checkOutput("rst_data", {24'b0, bus.ks_data}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_alu_op", {28'b0, bus.alu_op}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        $display("[TB] basic run");
        runStream(7'h60, 7'h01, 6'd7, 7, -1, -1);
        checkEndOfRun();

        $display("[TB] backpressure on byte 3");
        runStream(7'h60, 7'h01, 6'd7, 7, 2, -1);
        checkEndOfRun();

        $display("[TB] start while busy");
        runStream(7'h60, 7'h01, 6'd7, 7, -1, 1);
        checkEndOfRun();

        $display("[TB] zero length");
        applyStimulus(1'b1, 7'h60, 7'h01, 6'd0, 1'b1);
        @(negedge Clk);
        start = 1'b0;
        checkOutput("len0_done", {31'b0, done}, 32'd1);
        checkOutput("len0_busy", {31'b0, busy}, 32'd0);
        checkOutput("len0_valid", {31'b0, bus.ks_valid}, 32'd0);
        @(negedge Clk);
        checkOutput("len0_done_clear", {31'b0, done}, 32'd0);
        checkOutput("len0_busy_idle", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge Clk);
        checkOutput("len0_no_valid", {31'b0, bus.ks_valid}, 32'd0);

        $display("[TB] reset mid-run");
        runStream(7'h60, 7'h01, 6'd7, 2, -1, -1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("midrst_valid", {31'b0, bus.ks_valid}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_data", {24'b0, bus.ks_data}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        runStream(7'h60, 7'h01, 6'd3, 3, -1, -1);
        checkEndOfRun();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
